miter_sweep_ctrl: RTL and testbench
===================================

// Module: miter_sweep_ctrl
// PURPOSE
// Sequencer for exhaustive equivalence checking of two implementations (A, B) of one
// 16-input, single-output combinational function, e.g. gate-level vs. crossbar mapping.
// Drives one input vector per granted cycle over [range_lo, range_hi] and compares f_a
// against f_b after a fixed evaluation latency. Reports equivalence, the first failing
// vector and the mismatch count. The evaluator is shared with other users; this block
// issues a vector only in cycles where grant=1.
// PARAMETERS
// N_IN      16  input vector width (x0 = bit 0)
// EVAL_LAT  2   cycles from vec_valid to f_a/f_b for that vector; legal values >=1
// PORTS
// clk           in   1       clock, rising edge
// rst_n         in   1       asynchronous reset, active low
// start         in   1       begin sweep; sampled only in IDLE
// range_lo      in   N_IN    first vector, inclusive; sampled on start
// range_hi      in   N_IN    last vector, inclusive; sampled on start
// stop_on_fail  in   1       stop issuing after the first mismatch; sampled on start
// grant         in   1       evaluator available this cycle
// vec_out       out  N_IN    vector to evaluator, registered
// vec_valid     out  1       vec_out issued this cycle
// f_a, f_b      in   1       outputs of implementations A and B
// busy          out  1       high in RUN and DRAIN
// done          out  1       one-cycle pulse at sweep end
// equiv         out  1       1 = no mismatch in the last sweep
// fail_vec      out  N_IN    first mismatching vector of the last sweep
// fail_cnt      out  N_IN+1  mismatch count of the last sweep
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE. All outputs go to 0, including equiv.
//   The delay line and the counter are cleared. A reset mid-sweep abandons the sweep
//   and does not pulse done.
// - IDLE: on start=1, latch lo/hi/stop_on_fail. Clear fail_cnt, fail_vec and the
//   first-fail flag. Set equiv=1.
//   - If lo>hi: the range is empty. Go to DONE; no vectors are issued.
//   - Otherwise go to RUN with cnt=lo.
// - cnt is N_IN+1 bits wide, so hi=all-ones terminates without wrap-around.
// - RUN: in each cycle with grant=1, register vec_out=cnt[N_IN-1:0] and vec_valid=1,
//   then cnt++. With grant=0: vec_valid=0 and vec_out holds its value.
//   - After issuing cnt==hi, go to DRAIN.
//   - No vector is skipped or duplicated.
// - Delay line: EVAL_LAT stages carrying (valid, vector). The vector issued in cycle t
//   is compared in cycle t+EVAL_LAT using the f_a/f_b present in that cycle.
// - Compare: when the tail stage is valid and f_a!=f_b:
//   - fail_cnt++, saturating at 2^N_IN; equiv<=0.
//   - fail_vec<=vector, first mismatch only.
//   - If stop_on_fail: the RUN->DRAIN transition takes effect in the same cycle as the
//     compare. The vector issued in that cycle is still compared.
// - DRAIN: no new issue. In-flight vectors are still compared and counted.
//   When the delay line is empty, go to DONE.
// - DONE: done=1 for one cycle, then IDLE. equiv, fail_vec and fail_cnt hold until the
//   next accepted start.
// - start while busy is ignored. grant is ignored outside RUN.
// - busy=1 exactly in RUN and DRAIN; done and busy are never high together.
// TESTING
// 1. lo=0, hi=15, f_a==f_b always, grant=1 -> vec_valid for 16 consecutive cycles,
//    vec_out 0..15. done arrives EVAL_LAT+1 cycles after the last issue.
//    equiv=1, fail_cnt=0.
// 2. lo=0, hi=0xFFFF, B differs from A only at 0x1234 -> exactly 65536 issues, no wrap.
//    equiv=0, fail_vec=0x1234, fail_cnt=1.
// 3. lo=0, hi=100, stop_on_fail=1, mismatches at 5,6,7, EVAL_LAT=2 -> last vector
//    issued is 7. fail_cnt=3, fail_vec=5, done follows the drain.
// 4. grant pattern 1,0,1,0 over lo=0, hi=7 -> vec_valid only in granted cycles.
//    vec_out sequence 0..7 with no gaps or repeats, 8 compares.
// 5. lo=10, hi=3 -> vec_valid never asserted. done pulses 2 cycles after start.
//    equiv=1, fail_cnt=0.
// 6. rst_n=0 mid-RUN -> all outputs 0 immediately (async), no done pulse.
//    A subsequent start with lo=0, hi=3 completes normally.

Source files
------------

// File: rtl/miter_sweep_ctrl.sv
// miter_sweep_ctrl
// Drives an exhaustive sweep of input vectors into a shared two-implementation
// evaluator (A vs B) and compares f_a against f_b EVAL_LAT cycles after each
// vector is issued. Vectors are only issued in cycles where the evaluator is
// granted. Reports equivalence, the first failing vector and the mismatch count.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   start_i              begin a sweep (sampled only in IDLE)
//   range_lo_i/hi_i      inclusive vector range, sampled on start
//   stop_on_fail_i       stop issuing after the first mismatch, sampled on start
//   grant_i              evaluator available this cycle
//   vec_out_o/valid_o    registered vector to the evaluator and its issue strobe
//   f_a_i, f_b_i         evaluator outputs for the vector issued EVAL_LAT ago
//   busy_o               sweep in progress (RUN or DRAIN)
//   done_o               one-cycle pulse at sweep end
//   equiv_o              1 when the last sweep had no mismatch
//   fail_vec_o           first mismatching vector of the last sweep
//   fail_cnt_o           mismatch count of the last sweep (saturates at 2^N_IN)
module miter_sweep_ctrl #(
  parameter int unsigned N_IN     = 16,
  parameter int unsigned EVAL_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [N_IN-1:0] range_lo_i,
  input  logic [N_IN-1:0] range_hi_i,
  input  logic            stop_on_fail_i,
  input  logic            grant_i,
  output logic [N_IN-1:0] vec_out_o,
  output logic            vec_valid_o,
  input  logic            f_a_i,
  input  logic            f_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            equiv_o,
  output logic [N_IN-1:0] fail_vec_o,
  output logic [N_IN:0]   fail_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  // Stages 0..EVAL_LAT-2 of the valid line. When none of them hold a vector
  // while draining, everything left in flight is compared by the time the
  // DONE state is left, so the results are final in the same cycle done pulses.
  localparam logic [EVAL_LAT:0] LA_MASK = (EVAL_LAT+1)'((1 << (EVAL_LAT-1)) - 1);
  localparam logic [N_IN:0]     CNT_ONE = (N_IN+1)'(1);

  state_e                          state_q, state_d;
  logic [N_IN:0]                   cnt_q;
  logic [N_IN-1:0]                 hi_q;
  logic                            stop_q;
  // Stage 0 is the output register itself; stage EVAL_LAT is the compare point.
  logic [EVAL_LAT:0]               vld_pipe_q;
  logic [EVAL_LAT:0][N_IN-1:0]     vec_pipe_q;
  logic                            done_q;
  logic                            equiv_q;
  logic                            first_q;
  logic [N_IN-1:0]                 fail_vec_q;
  logic [N_IN:0]                   fail_cnt_q;

  logic issue, accept;
  logic cmp_fail, stop_now, at_hi, drain_last;

  assign cmp_fail   = vld_pipe_q[EVAL_LAT] & (f_a_i ^ f_b_i);
  assign stop_now   = stop_q & cmp_fail;
  assign at_hi      = (cnt_q == {1'b0, hi_q});
  assign drain_last = ~|(vld_pipe_q & LA_MASK);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = (range_lo_i > range_hi_i) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // A failing compare blocks the issue decided in the same cycle.
        if (stop_now) begin
          state_d = S_DRAIN;
        end else if (grant_i) begin
          issue = 1'b1;
          if (at_hi) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (drain_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      stop_q     <= 1'b0;
      vld_pipe_q <= '0;
      vec_pipe_q <= '0;
      done_q     <= 1'b0;
      equiv_q    <= 1'b0;
      first_q    <= 1'b0;
      fail_vec_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      if (issue) begin
        vec_pipe_q[0] <= cnt_q[N_IN-1:0];
        cnt_q         <= cnt_q + CNT_ONE;
      end
      for (int k = 1; k <= EVAL_LAT; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        vec_pipe_q[k] <= vec_pipe_q[k-1];
      end

      done_q <= (state_q == S_DONE);

      if (cmp_fail) begin
        if (!fail_cnt_q[N_IN]) fail_cnt_q <= fail_cnt_q + CNT_ONE;
        equiv_q <= 1'b0;
        if (!first_q) begin
          fail_vec_q <= vec_pipe_q[EVAL_LAT];
          first_q    <= 1'b1;
        end
      end

      // Start only happens in IDLE with an empty delay line, so it safely
      // overrides the compare updates above.
      if (accept) begin
        cnt_q      <= {1'b0, range_lo_i};
        hi_q       <= range_hi_i;
        stop_q     <= stop_on_fail_i;
        equiv_q    <= 1'b1;
        first_q    <= 1'b0;
        fail_vec_q <= '0;
        fail_cnt_q <= '0;
      end
    end
  end

  assign vec_out_o   = vec_pipe_q[0];
  assign vec_valid_o = vld_pipe_q[0];
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o      = done_q;
  assign equiv_o     = equiv_q;
  assign fail_vec_o  = fail_vec_q;
  assign fail_cnt_o  = fail_cnt_q;

endmodule

// File: tb/tb_miter_sweep_ctrl.sv
// Directed bench for miter_sweep_ctrl: a table of sweeps plus a mid-run reset.
// A small evaluator model returns f_a/f_b EVAL_LAT cycles after each vector.
module tb_miter_sweep_ctrl;
  localparam int N   = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, grant = 1'b1;
  logic          f_a = 1'b0, f_b = 1'b0;
  logic [N-1:0]  lo = '0, hi = '0;
  logic [N-1:0]  vec_out, fail_vec;
  logic          vec_valid, busy, done, equiv;
  logic [N:0]    fail_cnt;

  always #5 clk = ~clk;

  miter_sweep_ctrl #(.N_IN(N), .EVAL_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .range_lo_i(lo), .range_hi_i(hi), .stop_on_fail_i(stop), .grant_i(grant),
    .vec_out_o(vec_out), .vec_valid_o(vec_valid), .f_a_i(f_a), .f_b_i(f_b),
    .busy_o(busy), .done_o(done), .equiv_o(equiv),
    .fail_vec_o(fail_vec), .fail_cnt_o(fail_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Owned by the stimulus process.
  int mode = 0;
  bit galt = 1'b0;

  // Owned by the monitor.
  int           issues_tot = 0, seq_err = 0, gnt_err = 0, overlap = 0, done_tot = 0;
  int           last_issue_cyc = 0;
  logic [N-1:0] first_vec = '0, last_vec = '0, ln1 = '0, ln2 = '0;
  bit           have_prev = 1'b0;

  // Vectors where implementation B disagrees with A.
  function automatic bit bad(input int m, input logic [N-1:0] v);
    case (m)
      1:       return v == 16'h1234;
      2:       return (v >= 16'd5) && (v <= 16'd7);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) have_prev = 1'b0;
    if (vec_valid) begin
      issues_tot++;
      if (!grant) gnt_err++;
      if (have_prev && vec_out != last_vec + 16'd1) seq_err++;
      if (!have_prev) first_vec = vec_out;
      have_prev      = 1'b1;
      last_vec       = vec_out;
      last_issue_cyc = cyc;
    end
    if (done) begin
      done_tot++;
      have_prev = 1'b0;
      if (busy) overlap++;
    end
    // ln2 holds the vector output LAT cycles before the compare this drives.
    f_a = 1'($urandom_range(0, 1));
    f_b = f_a ^ bad(mode, ln2);
    ln2 = ln1;
    ln1 = vec_out;
    grant = galt ? ~grant : 1'b1;
  end

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  typedef struct {
    bit           galt;
    int           mode;
    logic [N-1:0] lo, hi;
    bit           stop, poke;
    int           issues;
    logic [N-1:0] lastv;
    bit           equiv;
    logic [N-1:0] fvec;
    int           fcnt;
  } vec_t;

  task automatic run_case(input vec_t v, input string tag);
    int s_cyc, d_cyc, i0, d0, se0, g0, o0;
    bit seen;
    mode = v.mode;
    galt = v.galt;
    @(negedge clk);
    lo = v.lo; hi = v.hi; stop = v.stop; start = 1'b1;
    s_cyc = cyc; i0 = issues_tot; d0 = done_tot; se0 = seq_err; g0 = gnt_err; o0 = overlap;
    @(negedge clk);
    start = 1'b0;
    if (v.poke) begin
      // A start while busy must not disturb the running sweep.
      repeat (4) @(negedge clk);
      lo = 16'd100; hi = 16'd200; stop = ~v.stop; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen  = 1'b0;
    d_cyc = 0;
    for (int k = 0; k < 70000 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        d_cyc = cyc;
      end
    end
    chk($sformatf("%s.done_seen", tag), seen, 1);
    repeat (3) @(negedge clk);
    chk($sformatf("%s.issues", tag), issues_tot - i0, v.issues);
    if (v.issues > 0) begin
      chk($sformatf("%s.first_vec", tag), first_vec, v.lo);
      chk($sformatf("%s.last_vec", tag), last_vec, v.lastv);
      chk($sformatf("%s.done_after_last_issue", tag), d_cyc - last_issue_cyc, LAT + 1);
    end else begin
      chk($sformatf("%s.done_after_start", tag), d_cyc - s_cyc, 2);
    end
    chk($sformatf("%s.seq_gaps", tag), seq_err - se0, 0);
    chk($sformatf("%s.ungranted_issue", tag), gnt_err - g0, 0);
    chk($sformatf("%s.done_pulses", tag), done_tot - d0, 1);
    chk($sformatf("%s.done_with_busy", tag), overlap - o0, 0);
    chk($sformatf("%s.busy_idle", tag), busy, 0);
    chk($sformatf("%s.equiv", tag), equiv, v.equiv);
    chk($sformatf("%s.fail_vec", tag), fail_vec, v.fvec);
    chk($sformatf("%s.fail_cnt", tag), fail_cnt, v.fcnt);
  endtask

  vec_t tbl[10];

  initial begin
    int d0;
    //           galt mode lo        hi        stop poke issues lastv     eq   fvec      fcnt
    tbl[0] = '{1'b0, 0, 16'd0,    16'd15,   1'b0, 1'b0, 16,    16'd15,   1'b1, 16'd0,    0};
    tbl[1] = '{1'b0, 1, 16'd0,    16'hFFFF, 1'b0, 1'b0, 65536, 16'hFFFF, 1'b0, 16'h1234, 1};
    tbl[2] = '{1'b0, 2, 16'd0,    16'd100,  1'b1, 1'b0, 8,     16'd7,    1'b0, 16'd5,    3};
    tbl[3] = '{1'b1, 0, 16'd0,    16'd7,    1'b0, 1'b0, 8,     16'd7,    1'b1, 16'd0,    0};
    tbl[4] = '{1'b0, 0, 16'd10,   16'd3,    1'b0, 1'b0, 0,     16'd0,    1'b1, 16'd0,    0};
    tbl[5] = '{1'b1, 3, 16'd0,    16'd7,    1'b0, 1'b0, 8,     16'd7,    1'b0, 16'd0,    8};
    tbl[6] = '{1'b0, 3, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1,     16'hFFFF, 1'b0, 16'hFFFF, 1};
    tbl[7] = '{1'b0, 2, 16'd0,    16'd20,   1'b0, 1'b1, 21,    16'd20,   1'b0, 16'd5,    3};
    tbl[8] = '{1'b0, 3, 16'd10,   16'd19,   1'b0, 1'b0, 10,    16'd19,   1'b0, 16'd10,   10};
    tbl[9] = '{1'b1, 2, 16'd3,    16'd9,    1'b1, 1'b0, 4,     16'd6,    1'b0, 16'd5,    2};

    #12;
    chk("reset.vec_valid", vec_valid, 0);
    chk("reset.vec_out", vec_out, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.equiv", equiv, 0);
    chk("reset.fail_vec", fail_vec, 0);
    chk("reset.fail_cnt", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_case(tbl[i], $sformatf("case%0d", i));

    // Reset in the middle of a sweep: outputs clear at once, no done pulse.
    mode = 0;
    galt = 1'b0;
    @(negedge clk);
    lo = 16'd0; hi = 16'd1000; stop = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrun.busy", busy, 1);
    chk("midrun.equiv", equiv, 1);
    d0 = done_tot;
    #1 rst_n = 1'b0;
    #1;
    chk("abort.vec_valid", vec_valid, 0);
    chk("abort.vec_out", vec_out, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.equiv", equiv, 0);
    chk("abort.fail_vec", fail_vec, 0);
    chk("abort.fail_cnt", fail_cnt, 0);
    repeat (3) @(negedge clk);
    chk("abort.no_done", done_tot - d0, 0);
    rst_n = 1'b1;
    run_case('{1'b0, 0, 16'd0, 16'd3, 1'b0, 1'b0, 4, 16'd3, 1'b1, 16'd0, 0}, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
